// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-client SRAM arbiter.
// Holds default geometry, FSM state encoding and client id values.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;

  // One stage of the read-return pipe: a read is in flight for client id.
  typedef struct packed {
    logic valid;
    logic id;
  } ret_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-winner pointer.
// On contention the client that did not win most recently is granted.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_reg;
  logic last_next;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    last_next = last_reg;
    if (en) begin
      if (req0 && (!req1 || last_reg == CLI1)) begin
        gnt0      = 1'b1;
        last_next = CLI0;
      end else if (req1) begin
        gnt1      = 1'b1;
        last_next = CLI1;
      end
    end
  end

  // Resetting to "client 1 won last" makes client 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= CLI1;
    end else begin
      last_reg <= last_next;
    end
  end

endmodule

// File: rtl/sram_128x8_arbiter.sv
// Round-robin sequencer in front of a single SRAM_128x8 with a 2-cycle read return.
// Optional power-up fill sweep enabled by defining SRAM_ARB_INIT_EN.
module sram_128x8_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                 ADDR_W     = ADDR_W_DEF,
  parameter int                 DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  INIT_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              init_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef SRAM_ARB_INIT_EN
  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   cnt_reg;
  logic [ADDR_W-1:0]   cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // One fill write per cycle; leaving INIT on the edge that issues the last address.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == ST_INIT) begin
      cnt_next = cnt_reg + 1'b1;
      if (&cnt_reg) begin
        state_next = ST_RUN;
      end
    end
  end

  assign init_busy = (state_reg == ST_INIT);
`else
  assign init_busy = 1'b0;
`endif

  logic arb_en;
  logic grant;

  assign arb_en = ~init_busy & ~rst;

  rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign grant = gnt0 | gnt1;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              mem_we_reg,    mem_we_next;
  logic              mem_re_reg,    mem_re_next;

  always_comb begin
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_we_next    = 1'b0;
    mem_re_next    = 1'b0;
`ifdef SRAM_ARB_INIT_EN
    if (init_busy) begin
      mem_addr_next  = cnt_reg;
      mem_wdata_next = INIT_VALUE;
      mem_we_next    = 1'b1;
    end else
`endif
    if (grant) begin
      mem_addr_next  = sel_addr;
      mem_wdata_next = sel_wdata;
      mem_we_next    = sel_we;
      mem_re_next    = ~sel_we;
    end
  end

  // Clearing the strobes asynchronously aborts whatever command is on the SRAM pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
    end else begin
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_we_reg    <= mem_we_next;
      mem_re_reg    <= mem_re_next;
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_we    = mem_we_reg;
  assign mem_re    = mem_re_reg;

  ret_tag_t s1_reg, s1_next;
  ret_tag_t s2_reg;

  always_comb begin
    s1_next       = '0;
    s1_next.valid = grant & ~sel_we;
    s1_next.id    = gnt1 ? CLI1 : CLI0;
  end

  // Stage 1 tracks the command on the SRAM pins, stage 2 the cycle its data is out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= s1_next;
      s2_reg <= s1_reg;
    end
  end

  assign rvalid0 = s2_reg.valid && (s2_reg.id == CLI0);
  assign rvalid1 = s2_reg.valid && (s2_reg.id == CLI1);
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_sram_128x8_arbiter.sv
// Randomised and directed bench for sram_128x8_arbiter with a behavioural SRAM and
// a reference model that tracks memory contents in grant order plus expected returns.
module tb_sram_128x8_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, init_busy, mem_we, mem_re;
  logic [7:0] rdata0, rdata1, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic [6:0] mem_addr;

  sram_128x8_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .init_busy(init_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Behavioural SRAM_128x8: acts on the edge where its enables are seen.
  logic [7:0] sram [128];
  always @(posedge clk) begin
    if (mem_re) mem_rdata = sram[mem_addr];
    if (mem_we) sram[mem_addr] = mem_wdata;
  end

`ifdef SRAM_ARB_INIT_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: memory image updated at grant time, queue of due read returns.
  typedef struct {
    int         due;
    bit         cli;
    logic [7:0] data;
  } ret_t;
  logic [7:0] ref_mem [128];
  ret_t       ret_q [$];
  bit         ref_last = 1'b1;
  int         cyc = 0;

  bit         eg0, eg1, ev0, ev1, og0, og1, ov0, ov1;
  logic [7:0] ed, od0, od1;

  // One clock cycle: sample DUT at negedge, predict, advance, drop consumed requests.
  task automatic step();
    ret_t e;
    @(negedge clk);
    og0 = gnt0; og1 = gnt1; ov0 = rvalid0; ov1 = rvalid1; od0 = rdata0; od1 = rdata1;
    eg0 = req0 && (!req1 || ref_last);
    eg1 = req1 && !eg0;
    ev0 = 1'b0; ev1 = 1'b0; ed = '0;
    if (ret_q.size() != 0 && ret_q[0].due == cyc) begin
      e = ret_q.pop_front();
      ev0 = !e.cli; ev1 = e.cli; ed = e.data;
    end
    if (eg0) begin
      ref_last = 1'b0;
      if (we0) ref_mem[addr0] = wdata0;
      else ret_q.push_back('{due: cyc + 2, cli: 1'b0, data: ref_mem[addr0]});
    end
    if (eg1) begin
      ref_last = 1'b1;
      if (we1) ref_mem[addr1] = wdata1;
      else ret_q.push_back('{due: cyc + 2, cli: 1'b1, data: ref_mem[addr1]});
    end
    cyc++;
    @(posedge clk);
    #1;
    if (og0) req0 = 1'b0;
    if (og1) req1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    ret_q.delete();
    ref_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    if (INIT_ON) begin
      repeat (128) @(posedge clk);
      #1;
      for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    end
  endtask

  task automatic test_reset();
    req0 = 1'b1;
    #2;
    checks++; if (gnt0 !== 1'b0) begin failures++; $display("FAIL rst_gnt0 got=%0b exp=0", gnt0); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {mem_we, mem_re}); end
    checks++; if ({mem_addr, mem_wdata} !== 15'h0) begin failures++; $display("FAIL rst_addr_data got=%h exp=0", {mem_addr, mem_wdata}); end
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", {rvalid0, rvalid1}); end
    checks++; if (init_busy !== INIT_ON) begin failures++; $display("FAIL rst_init_busy got=%0b exp=%0b", init_busy, INIT_ON); end
    do_reset();
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL run_init_busy got=%0b exp=0", init_busy); end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h00; wdata0 = 8'hAA;
    step();
    checks++; if (og0 !== 1'b1) begin failures++; $display("FAIL wr_gnt0 got=%0b exp=1", og0); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h00;
    step();
    checks++; if (og0 !== 1'b1 || og1 !== 1'b0) begin failures++; $display("FAIL rd_gnt got=%0b%0b exp=10", og0, og1); end
    step();
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL rd_early_rvalid0 got=%0b exp=0", ov0); end
    step();
    checks++; if (ov0 !== 1'b1 || ov1 !== 1'b0) begin failures++; $display("FAIL rd_rvalid got=%0b%0b exp=10", ov0, ov1); end
    checks++; if (od0 !== 8'hAA) begin failures++; $display("FAIL rd_rdata0 got=%h exp=aa", od0); end
    $display("test_write_read done");
  endtask

  task automatic test_alternate();
    bit prev_g0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'h01;
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'h02;
      end
      step();
      checks++; if (og0 !== eg0 || og1 !== eg1) begin failures++; $display("FAIL alt_gnt cyc=%0d got=%0b%0b exp=%0b%0b", i, og0, og1, eg0, eg1); end
      if (i > 0 && i < 8) begin
        checks++; if (og0 === prev_g0) begin failures++; $display("FAIL alt_toggle cyc=%0d got=%0b exp=%0b", i, og0, !prev_g0); end
      end
      prev_g0 = og0;
      checks++; if (ov0 !== ev0 || ov1 !== ev1) begin failures++; $display("FAIL alt_rvalid cyc=%0d got=%0b%0b exp=%0b%0b", i, ov0, ov1, ev0, ev1); end
      if (ev0 || ev1) begin
        checks++; if (od0 !== ed) begin failures++; $display("FAIL alt_rdata cyc=%0d got=%h exp=%h", i, od0, ed); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    $display("test_alternate done");
  endtask

  task automatic test_raw();
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h01; wdata1 = 8'hCC;
    step();
    checks++; if (og1 !== 1'b1) begin failures++; $display("FAIL raw_wr_gnt1 got=%0b exp=1", og1); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h01;
    step();
    checks++; if (og0 !== 1'b1) begin failures++; $display("FAIL raw_rd_gnt0 got=%0b exp=1", og0); end
    step();
    step();
    checks++; if (ov0 !== 1'b1 || od0 !== 8'hCC) begin failures++; $display("FAIL raw_rdata0 got=%0b/%h exp=1/cc", ov0, od0); end
    $display("test_raw done");
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      req1 = 1'b1; we1 = 1'b1; addr1 = 7'(10 + i); wdata1 = 8'($urandom);
      step();
      checks++; if (og1 !== 1'b1) begin failures++; $display("FAIL stream_gnt1 beat=%0d got=%0b exp=1", i, og1); end
      checks++; if (mem_addr !== 7'(10 + i) || mem_we !== 1'b1) begin failures++; $display("FAIL stream_mem beat=%0d got=%h/%0b exp=%h/1", i, mem_addr, mem_we, 7'(10 + i)); end
    end
    step();
    $display("test_stream done");
  endtask

  task automatic test_reset_midop();
    logic [7:0] exp_d;
    exp_d = INIT_ON ? 8'h00 : 8'hAA;
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h00;
    step();
    checks++; if (og0 !== 1'b1) begin failures++; $display("FAIL midrst_gnt0 got=%0b exp=1", og0); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({mem_we, mem_re} !== 2'b00) begin failures++; $display("FAIL midrst_strobes got=%b exp=00", {mem_we, mem_re}); end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin failures++; $display("FAIL midrst_no_rvalid cyc=%0d got=%0b%0b exp=00", i, ov0, ov1); end
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h00;
    step();
    step();
    step();
    checks++; if (ov0 !== 1'b1 || od0 !== exp_d) begin failures++; $display("FAIL midrst_readback got=%0b/%h exp=1/%h", ov0, od0, exp_d); end
    $display("test_reset_midop done");
  endtask

`ifdef SRAM_ARB_INIT_EN
  task automatic test_init();
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h7F; wdata0 = 8'h33;
    step();
    step();
    rst = 1'b1;
    ret_q.delete();
    ref_last = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL init_busy_in_rst got=%0b exp=1", init_busy); end
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h00;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      checks++; if (init_busy !== 1'b1 || gnt0 !== 1'b0) begin failures++; $display("FAIL init_sweep cyc=%0d got=%0b/%0b exp=1/0", i, init_busy, gnt0); end
      @(posedge clk);
    end
    #1;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL init_done got=%0b exp=0", init_busy); end
    step();
    checks++; if (og0 !== 1'b1) begin failures++; $display("FAIL init_first_gnt got=%0b exp=1", og0); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h7F;
    step();
    step();
    checks++; if (ov0 !== 1'b1 || od0 !== 8'h00) begin failures++; $display("FAIL init_rd00 got=%0b/%h exp=1/00", ov0, od0); end
    step();
    checks++; if (ov0 !== 1'b1 || od0 !== 8'h00) begin failures++; $display("FAIL init_rd7f got=%0b/%h exp=1/00", ov0, od0); end
    $display("test_init done");
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i < 394) begin
        if (!req0 && $urandom_range(9, 0) < 6) begin
          req0 = 1'b1; we0 = 1'($urandom_range(1, 0)); addr0 = 7'($urandom_range(15, 0)); wdata0 = 8'($urandom);
        end
        if (!req1 && $urandom_range(9, 0) < 6) begin
          req1 = 1'b1; we1 = 1'($urandom_range(1, 0)); addr1 = 7'($urandom_range(15, 0)); wdata1 = 8'($urandom);
        end
      end
      step();
      checks++; if (og0 !== eg0 || og1 !== eg1) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%0b%0b exp=%0b%0b", i, og0, og1, eg0, eg1); end
      checks++; if (ov0 !== ev0 || ov1 !== ev1) begin failures++; $display("FAIL rnd_rvalid cyc=%0d got=%0b%0b exp=%0b%0b", i, ov0, ov1, ev0, ev1); end
      if (ev0) begin
        checks++; if (od0 !== ed) begin failures++; $display("FAIL rnd_rdata0 cyc=%0d got=%h exp=%h", i, od0, ed); end
      end
      if (ev1) begin
        checks++; if (od1 !== ed) begin failures++; $display("FAIL rnd_rdata1 cyc=%0d got=%h exp=%h", i, od1, ed); end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      sram[i] = 8'($urandom);
      ref_mem[i] = sram[i];
    end
    test_reset();
    test_write_read();
    test_alternate();
    test_raw();
    test_stream();
    test_reset_midop();
`ifdef SRAM_ARB_INIT_EN
    test_init();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
